// File: rtl/mux4x2_rr_arb_if.sv
// Handshake bundle between the lane requesters, the arbiter and the
// downstream consumer of the 4:1 x 2-bit mux output.
interface mux4x2_rr_arb_if;
  logic [3:0] REQ;
  logic [1:0] S;
  logic [3:0] GRANT;
  logic       VALID;
  logic       READY;
  logic [3:0] ACK;

  modport master (
    input  REQ,
    input  READY,
    output S,
    output GRANT,
    output VALID,
    output ACK
  );

  modport slave (
    output REQ,
    output READY,
    input  S,
    input  GRANT,
    input  VALID,
    input  ACK
  );
endinterface

// File: rtl/mux4x2_rr_arb.sv
// Round-robin burst arbiter driving the select of a 4-input 2-bit mux.
// Define MUX4X2_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mux4x2_rr_arb #(
  parameter int unsigned BURST = 1
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  mux4x2_rr_arb_if.master bus
);

  typedef enum logic {IDLE, GNT} state_t;

  state_t     state, state_n;
  logic [1:0] s_q, s_n;
  logic [3:0] grant_q, grant_n;
  logic       valid_q, valid_n;
  logic [1:0] pick;
  logic       fire;

  assign fire      = valid_q & bus.READY;
  assign bus.S     = s_q;
  assign bus.GRANT = grant_q;
  assign bus.VALID = valid_q;
  assign bus.ACK   = grant_q & {4{fire}};

`ifdef MUX4X2_ARB_FIXED_PRIO_EN

  // Lowest-index requesting lane wins
  always_comb begin
    pick = 2'd0;
    if (bus.REQ[0])      pick = 2'd0;
    else if (bus.REQ[1]) pick = 2'd1;
    else if (bus.REQ[2]) pick = 2'd2;
    else if (bus.REQ[3]) pick = 2'd3;
  end

  // Next-state and grant decision
  always_comb begin
    state_n = state;
    s_n     = s_q;
    grant_n = grant_q;
    valid_n = valid_q;
    unique case (state)
      IDLE: begin
        if (bus.REQ != 4'd0) begin
          s_n     = pick;
          grant_n = 4'(1) << pick;
          valid_n = 1'b1;
          state_n = GNT;
        end
      end
      GNT: begin
        if (fire) begin
          valid_n = 1'b0;
          grant_n = 4'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state   <= IDLE;
      s_q     <= 2'd0;
      grant_q <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      s_q     <= s_n;
      grant_q <= grant_n;
      valid_q <= valid_n;
    end
  end

`else

  localparam logic [3:0] BURST_L = 4'(BURST);

  logic [1:0] ptr_q, ptr_n;
  logic [3:0] cnt_q, cnt_n;
  logic       cont;

  assign cont = (cnt_q != 4'd0) && (cnt_q < BURST_L) && bus.REQ[ptr_q];

  // First requester scanning from the lane after the last one granted
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.REQ[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state, burst accounting and grant decision
  always_comb begin
    state_n = state;
    s_n     = s_q;
    grant_n = grant_q;
    valid_n = valid_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: begin
        if (bus.REQ == 4'd0) begin
          cnt_n = 4'd0;
        end else if (cont) begin
          s_n     = ptr_q;
          grant_n = 4'(1) << ptr_q;
          valid_n = 1'b1;
          state_n = GNT;
        end else begin
          s_n     = pick;
          grant_n = 4'(1) << pick;
          valid_n = 1'b1;
          cnt_n   = 4'd0;
          state_n = GNT;
        end
      end
      GNT: begin
        if (fire) begin
          ptr_n   = s_q;
          cnt_n   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          valid_n = 1'b0;
          grant_n = 4'd0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers; ptr resets to 3 so lane 0 wins first
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state   <= IDLE;
      s_q     <= 2'd0;
      grant_q <= 4'd0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd3;
      cnt_q   <= 4'd0;
    end else begin
      state   <= state_n;
      s_q     <= s_n;
      grant_q <= grant_n;
      valid_q <= valid_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
    end
  end

`endif

endmodule

// File: tb/tb_mux4x2_rr_arb.sv
// Bench for mux4x2_rr_arb: table vectors, corner sequences and a
// transaction-level reference model on BURST=1 and BURST=3 instances.
module tb_mux4x2_rr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       rdy;
  bit         mchk;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  mux4x2_rr_arb_if if1 ();
  mux4x2_rr_arb_if if3 ();

  assign if1.REQ   = req;
  assign if1.READY = rdy;
  assign if3.REQ   = req;
  assign if3.READY = rdy;

  mux4x2_rr_arb #(.BURST(1)) dut1 (
    .CLK(clk),
    .ASYNCRESETN(rst_n),
    .bus(if1.master)
  );

  mux4x2_rr_arb #(.BURST(3)) dut3 (
    .CLK(clk),
    .ASYNCRESETN(rst_n),
    .bus(if3.master)
  );

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [1:0] s;
    logic [3:0] g;
    logic       v;
    logic [3:0] a;
  } vec_t;

  vec_t tbl[10];

  // Reference model: per instance, transfers completed, index where
  // the current burst began, last lane served, and a pending offer.
  bit m_busy[2];
  int m_s[2];
  int m_last[2];
  int m_total[2];
  int m_bstart[2];

  function automatic int burst_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k]   = 1'b0;
      m_s[k]      = 0;
      m_last[k]   = 3;
      m_total[k]  = 0;
      m_bstart[k] = 0;
    end
  endtask

  task automatic model_step(int k, logic [3:0] r, logic rd);
    int run;
    int lane;
    if (!m_busy[k]) begin
      if (r != 4'd0) begin
`ifdef MUX4X2_ARB_FIXED_PRIO_EN
        lane = -1;
        for (int i = 0; i < 4; i++)
          if (lane < 0 && r[i]) lane = i;
`else
        run = m_total[k] - m_bstart[k];
        if (run > 0 && run < burst_of(k) && r[m_last[k]]) begin
          lane = m_last[k];
        end else begin
          lane = -1;
          for (int i = 1; i <= 4; i++)
            if (lane < 0 && r[(m_last[k] + i) % 4])
              lane = (m_last[k] + i) % 4;
          m_bstart[k] = m_total[k];
        end
`endif
        m_s[k]    = lane;
        m_busy[k] = 1'b1;
      end else begin
        m_bstart[k] = m_total[k];
      end
    end else if (rd) begin
      m_total[k]++;
      m_last[k] = m_s[k];
      m_busy[k] = 1'b0;
    end
  endtask

  task automatic mcheck(int k, logic [1:0] s, logic [3:0] g,
                        logic v, logic [3:0] a);
    logic [3:0] eg;
    logic [3:0] ea;
    eg = m_busy[k] ? (4'(1) << m_s[k]) : 4'd0;
    ea = (m_busy[k] && rdy) ? eg : 4'd0;
    chk($sformatf("model%0d_valid", k), v, m_busy[k]);
    chk($sformatf("model%0d_s", k), s, m_s[k]);
    chk($sformatf("model%0d_grant", k), g, eg);
    chk($sformatf("model%0d_ack", k), a, ea);
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0, req, rdy);
      model_step(1, req, rdy);
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      #2;
      mcheck(0, if1.S, if1.GRANT, if1.VALID, if1.ACK);
      mcheck(1, if3.S, if3.GRANT, if3.VALID, if3.ACK);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    req = 4'd0;
    rdy = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int bq[$];
    int bexp[7];
    int lane;
    int prev;

    for (int i = 0; i < 5; i++) begin
`ifdef MUX4X2_ARB_FIXED_PRIO_EN
      lane = 0;
      prev = 0;
`else
      lane = i % 4;
      prev = (i == 0) ? 0 : (i - 1) % 4;
`endif
      tbl[2*i]   = '{4'hF, 1'b1, 2'(prev), 4'd0, 1'b0, 4'd0};
      tbl[2*i+1] = '{4'hF, 1'b1, 2'(lane), 4'(1) << lane,
                     1'b1, 4'(1) << lane};
    end
`ifdef MUX4X2_ARB_FIXED_PRIO_EN
    bexp = '{0, 0, 0, 0, 0, 0, 0};
`else
    bexp = '{0, 0, 0, 1, 1, 1, 0};
`endif

    rst_n = 1'b0;
    req   = 4'd0;
    rdy   = 1'b0;
    mchk  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rdy = 1'b1;
    #1;
    chk("rst_s", if1.S, 2'd0);
    chk("rst_grant", if1.GRANT, 4'd0);
    chk("rst_valid", if1.VALID, 1'b0);
    chk("rst_ack", if1.ACK, 4'd0);
    rst_n = 1'b1;
    rdy   = 1'b0;
    mchk  = 1'b1;

    // rotation table on the BURST=1 instance
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req = tbl[i].req;
      rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_s", i), if1.S, tbl[i].s);
      chk($sformatf("tbl%0d_grant", i), if1.GRANT, tbl[i].g);
      chk($sformatf("tbl%0d_valid", i), if1.VALID, tbl[i].v);
      chk($sformatf("tbl%0d_ack", i), if1.ACK, tbl[i].a);
    end

    // backpressure: grant holds, no ack until READY
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_valid", if1.VALID, 1'b1);
      chk("bp_s", if1.S, 2'd2);
      chk("bp_grant", if1.GRANT, 4'b0100);
      chk("bp_ack", if1.ACK, 4'd0);
    end
    @(negedge clk);
    rdy = 1'b1;
    #1;
    chk("bp_fire_ack", if1.ACK, 4'b0100);
    @(negedge clk);
    rdy = 1'b0;
    req = 4'd0;
    #1;
    chk("bp_bubble_valid", if1.VALID, 1'b0);
    chk("bp_bubble_grant", if1.GRANT, 4'd0);

    // burst of 3 on two lanes
    do_reset();
    @(negedge clk);
    req = 4'b0011;
    rdy = 1'b1;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (if3.VALID) bq.push_back(int'(if3.S));
    end
    chk("burst_count", bq.size() >= 7, 1'b1);
    for (int i = 0; i < 7; i++)
      if (i < bq.size())
        chk($sformatf("burst_lane%0d", i), bq[i], bexp[i]);

    // burst cut short by the request pattern seen in the bubble
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    rdy = 1'b1;
    @(negedge clk);
    #1;
    chk("cut_first_s", if3.S, 2'd0);
    chk("cut_first_valid", if3.VALID, 1'b1);
    @(negedge clk);
    req = 4'b0010;
    #1;
    chk("cut_bubble_valid", if3.VALID, 1'b0);
    @(negedge clk);
    #1;
    chk("cut_next_s", if3.S, 2'd1);
    chk("cut_next_grant", if3.GRANT, 4'b0010);
    req = 4'b0011;
    repeat (12) @(negedge clk);

    // asynchronous reset in the middle of a grant
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    rdy = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_pre_valid", if1.VALID, 1'b1);
    chk("mid_pre_s", if1.S, 2'd2);
    #2;
    rdy   = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", if1.VALID, 1'b0);
    chk("mid_grant", if1.GRANT, 4'd0);
    chk("mid_s", if1.S, 2'd0);
    chk("mid_ack", if1.ACK, 4'd0);
    @(negedge clk);
    req = 4'hF;
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_s", if1.S, 2'd0);
    chk("rel_grant", if1.GRANT, 4'b0001);
    chk("rel_valid", if1.VALID, 1'b1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (n % 750 == 749) do_reset();
      @(negedge clk);
      req = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    #3;
    mchk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
